// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: opcode constants, forwarding selects and the
// per-stage shadow record tracked by the hazard controller.
package riscv_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes;
    logic              is_load;
  } stage_info_t;

  localparam stage_info_t STAGE_EMPTY = '0;

  // The youngest producer wins: EX holds newer data than MEM.
  function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex) begin
      return FWD_EXMEM;
    end else if (hit_mem) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_match.sv
// hazard_match: does one decode source register depend on one in-flight stage.
// Ports:
//   rs_i     source register address
//   uses_i   decode instruction actually reads rs_i
//   stage_i  shadow record of the stage under test
//   match_o  dependency exists (x0 never matches)
module hazard_match
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic              uses_i,
  input  stage_info_t       stage_i,
  output logic              match_o
);

  assign match_o = stage_i.valid && stage_i.writes && uses_i &&
                   (rs_i != '0) && (stage_i.rd == rs_i);

  // Load-ness matters to the caller, not to the address compare.
  logic unused_is_load;
  assign unused_is_load = stage_i.is_load;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall / flush / forward-select controller for the 5-stage
// RV32I pipeline. Tracks rd of instructions in EX, MEM and WB and compares
// them with the decode-stage sources.
// Build option: FORWARDING_EN enables EX/MEM and MEM/WB forwarding; when
// undefined every RAW hazard on EX or MEM stalls and fwd_*_o are tied to 00.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   id_*_i                decoded fields of the instruction in ID
//   ex_redirect_i         taken branch/jump resolved in EX
//   mem_ready_i           data memory done; low freezes the pipeline
//   if_stall_o/id_stall_o hold IF and ID, bubble into EX
//   if_flush_o/id_flush_o squash IF/ID and ID
//   freeze_o              hold every pipeline register
//   fwd_a_o/fwd_b_o       operand source for the instruction in EX
module pipeline_ctrl
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_writes_rd_i,
  input  logic        id_is_load_i,
  input  logic        ex_redirect_i,
  input  logic        mem_ready_i,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        if_flush_o,
  output logic        id_flush_o,
  output logic        freeze_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o
);

  stage_info_t ex_q, mem_q, wb_q, ex_d;

  logic a_ex, b_ex, a_mem, b_mem;
  logic freeze, redirect, hazard, id_stall, id_flush, issue;

  hazard_match u_a_ex (
    .rs_i    (id_rs1_i),
    .uses_i  (id_uses_rs1_i),
    .stage_i (ex_q),
    .match_o (a_ex)
  );

  hazard_match u_b_ex (
    .rs_i    (id_rs2_i),
    .uses_i  (id_uses_rs2_i),
    .stage_i (ex_q),
    .match_o (b_ex)
  );

  hazard_match u_a_mem (
    .rs_i    (id_rs1_i),
    .uses_i  (id_uses_rs1_i),
    .stage_i (mem_q),
    .match_o (a_mem)
  );

  hazard_match u_b_mem (
    .rs_i    (id_rs2_i),
    .uses_i  (id_uses_rs2_i),
    .stage_i (mem_q),
    .match_o (b_mem)
  );

  // Stall/flush arbitration: freeze > redirect > hazard.
  always_comb begin
    freeze   = !mem_ready_i;
    redirect = ex_redirect_i && !freeze;
`ifdef FORWARDING_EN
    hazard   = (a_ex || b_ex) && ex_q.is_load;
`else
    hazard   = a_ex || b_ex || a_mem || b_mem;
`endif
    id_stall = hazard && !freeze && !redirect;
    id_flush = redirect;
    issue    = id_valid_i && !id_stall && !id_flush;

    ex_d = STAGE_EMPTY;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd_i;
      ex_d.writes  = id_writes_rd_i;
      ex_d.is_load = id_is_load_i;
    end
  end

  // Shadow pipeline; holds completely while frozen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= STAGE_EMPTY;
      mem_q <= STAGE_EMPTY;
      wb_q  <= STAGE_EMPTY;
    end else if (!freeze) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign freeze_o   = freeze;
  assign id_stall_o = id_stall;
  assign if_stall_o = id_stall;
  assign id_flush_o = id_flush;
  assign if_flush_o = id_flush;

`ifdef FORWARDING_EN
  fwd_sel_e fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  // Select is decided while the consumer is in ID, used during its EX cycle.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (issue) begin
      fwd_a_d = fwd_pick(a_ex, a_mem);
      fwd_b_d = fwd_pick(b_ex, b_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!freeze) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_o = 2'(fwd_a_q);
  assign fwd_b_o = 2'(fwd_b_q);

  // WB is write-through into the register file, so it never forwards or stalls.
  logic unused_state;
  assign unused_state = ^{wb_q, mem_q.is_load};
`else
  assign fwd_a_o = 2'(FWD_RF);
  assign fwd_b_o = 2'(FWD_RF);

  logic unused_state;
  assign unused_state = ^{wb_q, mem_q.is_load, ex_q.is_load};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; expectations follow the FORWARDING_EN build.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i, id_is_load_i;
  logic       ex_redirect_i, mem_ready_i;
  logic       if_stall_o, id_stall_o, if_flush_o, id_flush_o, freeze_o;
  logic [1:0] fwd_a_o, fwd_b_o;

  pipeline_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_uses_rs1_i  (id_uses_rs1_i),
    .id_uses_rs2_i  (id_uses_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_writes_rd_i (id_writes_rd_i),
    .id_is_load_i   (id_is_load_i),
    .ex_redirect_i  (ex_redirect_i),
    .mem_ready_i    (mem_ready_i),
    .if_stall_o     (if_stall_o),
    .id_stall_o     (id_stall_o),
    .if_flush_o     (if_flush_o),
    .id_flush_o     (id_flush_o),
    .freeze_o       (freeze_o),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
  } fwd_exp_t;

  fwd_exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0, wr: 1'b0, ld: 1'b0};
    return i;
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, u1: 1'b1, u2: 1'b1, wr: 1'b1, ld: 1'b0};
    return i;
  endfunction

  function automatic ins_t addi(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, u1: 1'b1, u2: 1'b0, wr: 1'b1, ld: 1'b0};
    return i;
  endfunction

  function automatic ins_t load(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, u1: 1'b1, u2: 1'b0, wr: 1'b1, ld: 1'b1};
    return i;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One cycle: drive ID/control, check combinational outputs mid-cycle,
  // queue the forward select expected after the edge, then compare it.
  task automatic step(input string tag, input ins_t ins, input logic rst, input logic redir,
                      input logic ready, input logic exp_stall, input logic exp_flush,
                      input logic [1:0] ea, input logic [1:0] eb);
    fwd_exp_t e;
    fwd_exp_t got;
    rst_i          = rst;
    id_valid_i     = ins.v;
    id_rs1_i       = ins.rs1;
    id_rs2_i       = ins.rs2;
    id_rd_i        = ins.rd;
    id_uses_rs1_i  = ins.u1;
    id_uses_rs2_i  = ins.u2;
    id_writes_rd_i = ins.wr;
    id_is_load_i   = ins.ld;
    ex_redirect_i  = redir;
    mem_ready_i    = ready;
    #1;
    chk({tag, ".id_stall"}, 2'(id_stall_o), 2'(exp_stall));
    chk({tag, ".if_stall"}, 2'(if_stall_o), 2'(exp_stall));
    chk({tag, ".id_flush"}, 2'(id_flush_o), 2'(exp_flush));
    chk({tag, ".if_flush"}, 2'(if_flush_o), 2'(exp_flush));
    chk({tag, ".freeze"},   2'(freeze_o),   2'(!ready));
    e.a = ea;
    e.b = eb;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    chk({tag, ".fwd_a"}, fwd_a_o, got.a);
    chk({tag, ".fwd_b"}, fwd_b_o, got.b);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      step("drain", nop(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    end
  endtask

  initial begin
    rst_i = 1'b1; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; id_writes_rd_i = 1'b0; id_is_load_i = 1'b0;
    ex_redirect_i = 1'b0; mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset state
    step("reset", nop(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    // ALU -> ALU back to back
    step("t1_add5", alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`ifdef FORWARDING_EN
    step("t1_add6", alu(5'd6, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
`else
    step("t1_add6_s1", alu(5'd6, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t1_add6_s2", alu(5'd6, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t1_add6",    alu(5'd6, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`endif
    drain();

    // Load-use
    step("t2_lw",    load(5'd5, 5'd1),         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t2_use_s", alu(5'd6, 5'd3, 5'd5),    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
`ifdef FORWARDING_EN
    step("t2_use",   alu(5'd6, 5'd3, 5'd5),    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10);
`else
    step("t2_use_s2", alu(5'd6, 5'd3, 5'd5),   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t2_use",    alu(5'd6, 5'd3, 5'd5),   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`endif
    drain();

    // x0 never creates a dependency
    step("t3_addi_x0", addi(5'd0, 5'd1),       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t3_use_x0",  alu(5'd6, 5'd0, 5'd0),  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();

    // Redirect beats load-use stall; squashed add must not reach EX
    step("t4_lw",    load(5'd5, 5'd1),         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t4_redir", alu(5'd6, 5'd3, 5'd5),    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    step("t4_after", alu(5'd7, 5'd6, 5'd0),    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();

    // Freeze for three cycles (redirect asserted but ignored), then resume
    step("t5_add5", alu(5'd5, 5'd1, 5'd2),     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`ifdef FORWARDING_EN
    step("t5_add6", alu(5'd6, 5'd5, 5'd3),     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    for (int k = 0; k < 3; k++) begin
      step("t5_frz", alu(5'd7, 5'd6, 5'd6),    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    end
    step("t5_resume", alu(5'd7, 5'd6, 5'd6),   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01);
`else
    step("t5_add6_s1", alu(5'd6, 5'd5, 5'd3),  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_add6_s2", alu(5'd6, 5'd5, 5'd3),  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_add6",    alu(5'd6, 5'd5, 5'd3),  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      step("t5_frz", alu(5'd7, 5'd6, 5'd6),    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    end
    step("t5_resume_s1", alu(5'd7, 5'd6, 5'd6), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_resume_s2", alu(5'd7, 5'd6, 5'd6), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_resume",    alu(5'd7, 5'd6, 5'd6), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`endif
    drain();

    // Reset during a stall clears the in-flight load
    step("t6_lw",    load(5'd5, 5'd1),         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t6_rst",   alu(5'd6, 5'd3, 5'd5),    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t6_after", alu(5'd6, 5'd3, 5'd5),    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();

    // Reset during a freeze clears state and forward selects
    step("t7_add5", alu(5'd5, 5'd1, 5'd2),     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
`ifdef FORWARDING_EN
    step("t7_add6", alu(5'd6, 5'd5, 5'd3),     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
`else
    step("t7_add6", alu(5'd6, 5'd5, 5'd3),     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
`endif
    step("t7_rstfrz", alu(5'd6, 5'd5, 5'd3),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t7_after",  alu(5'd7, 5'd6, 5'd6),   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
